// File: rtl/instr_sequencer_if.sv
// ============================================================================
// Module      : instr_sequencer_if
// Description : Program-ROM, control, status and debug bus of instr_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_sequencer_if;
    logic       run;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] pc;
    logic [7:0] acc;
    logic       zero_flag;
    logic       carry_flag;
    logic       instr_done;
    logic       halted;
    logic [3:0] dbg_sel;
    logic [7:0] dbg_data;

    // Sequencer side: fetches from the ROM and publishes its state
    modport master (
        input  run, rom_data, dbg_sel,
        output rom_addr, pc, acc, zero_flag, carry_flag,
               instr_done, halted, dbg_data
    );

    // Environment side: supplies ROM contents and control
    modport slave (
        output run, rom_data, dbg_sel,
        input  rom_addr, pc, acc, zero_flag, carry_flag,
               instr_done, halted, dbg_data
    );
endinterface

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module      : instr_sequencer
// Description : Two-cycle FETCH/EXEC accumulator machine with 16x8 reg file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_sequencer (
    input  wire logic             clk,
    input  wire logic             rst,
    instr_sequencer_if.master     bus
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [3:0] c_OP_LDI   = 4'h1;
    localparam logic [3:0] c_OP_ADD   = 4'h2;
    localparam logic [3:0] c_OP_SUB   = 4'h3;
    localparam logic [3:0] c_OP_AND   = 4'h4;
    localparam logic [3:0] c_OP_OR    = 4'h5;
    localparam logic [3:0] c_OP_XOR   = 4'h6;
    localparam logic [3:0] c_OP_NOT   = 4'h7;
    localparam logic [3:0] c_OP_JMP   = 4'h8;
    localparam logic [3:0] c_OP_JZ    = 4'h9;
    localparam logic [3:0] c_OP_STORE = 4'hA;
    localparam logic [3:0] c_OP_LDM   = 4'hB;
    localparam logic [3:0] c_OP_HALT  = 4'hD;

    logic [1:0] r_state;
    logic [3:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_acc;
    logic       r_z;
    logic       r_c;
    logic [7:0] r_regs [16];

    logic [3:0] w_opc;
    logic [3:0] w_opd;
    logic [7:0] w_rop;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_acc_next;
    logic       w_z_next;
    logic       w_c_next;
    logic [3:0] w_pc_next;
    logic       w_store;
    logic       w_halt;

    assign w_opc  = r_ir[7:4];
    assign w_opd  = r_ir[3:0];
    assign w_rop  = r_regs[w_opd];
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_rop};
    // Bit 8 of the 9-bit difference is the borrow (acc < R[op])
    assign w_diff = {1'b0, r_acc} - {1'b0, w_rop};

    always_comb begin
        w_acc_next = r_acc;
        w_c_next   = r_c;
        w_pc_next  = r_pc + 4'd1;
        w_store    = 1'b0;
        w_halt     = 1'b0;
        case (w_opc)
            c_OP_LDI:   w_acc_next = {4'h0, w_opd};
            c_OP_ADD:   {w_c_next, w_acc_next} = w_sum;
            c_OP_SUB:   {w_c_next, w_acc_next} = w_diff;
            c_OP_AND:   w_acc_next = r_acc & w_rop;
            c_OP_OR:    w_acc_next = r_acc | w_rop;
            c_OP_XOR:   w_acc_next = r_acc ^ w_rop;
            c_OP_NOT:   w_acc_next = ~r_acc;
            c_OP_JMP:   w_pc_next  = w_opd;
            c_OP_JZ:    if (r_z) w_pc_next = w_opd;
            c_OP_STORE: w_store    = 1'b1;
            c_OP_LDM:   w_acc_next = w_rop;
            c_OP_HALT: begin
                w_pc_next = r_pc;
                w_halt    = 1'b1;
            end
            default: ;
        endcase
        // Z tracks the accumulator only for data-path opcodes 1-7 and B
        if (((w_opc >= c_OP_LDI) && (w_opc <= c_OP_NOT)) || (w_opc == c_OP_LDM))
            w_z_next = (w_acc_next == 8'h00);
        else
            w_z_next = r_z;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= 4'h0;
            r_ir    <= 8'h00;
            r_acc   <= 8'h00;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            for (int k = 0; k < 16; k++)
                r_regs[k] <= 8'h00;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (bus.run) begin
                        r_ir    <= bus.rom_data;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_pc  <= w_pc_next;
                    r_acc <= w_acc_next;
                    r_z   <= w_z_next;
                    r_c   <= w_c_next;
                    if (w_store)
                        r_regs[w_opd] <= r_acc;
                    r_state <= w_halt ? ST_HALT : ST_FETCH;
                end
                default: ;
            endcase
        end
    end

    assign bus.rom_addr   = r_pc;
    assign bus.pc         = r_pc;
    assign bus.acc        = r_acc;
    assign bus.zero_flag  = r_z;
    assign bus.carry_flag = r_c;
    assign bus.instr_done = (r_state == ST_EXEC);
    assign bus.halted     = (r_state == ST_HALT);
    assign bus.dbg_data   = r_regs[bus.dbg_sel];

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed self-checking bench for instr_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] rom [16];
    int         n_cmp;
    int         n_err;
    int         n_done;

    instr_sequencer_if bus ();

    instr_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n edges, sampling 1 ns after each and counting done pulses
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.instr_done) n_done++;
        end
    endtask

    task automatic load_rom(input logic [7:0] fill);
        for (int i = 0; i < 16; i++) rom[i] = fill;
    endtask

    task automatic do_reset();
        bus.run = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_done = 0;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        n_done      = 0;
        rst         = 1'b1;
        bus.run     = 1'b0;
        bus.dbg_sel = 4'h0;

        // Arithmetic, zero/branch, JZ not-taken
        load_rom(8'hC0);
        rom[0] = 8'h12; rom[1] = 8'hA5; rom[2] = 8'h25;
        rom[3] = 8'hA6; rom[4] = 8'h36; rom[5] = 8'h99;
        rom[9] = 8'h12; rom[10] = 8'h9F;
        do_reset();
        check("rst_pc", bus.pc, 16'h0);
        check("rst_done", bus.instr_done, 16'h0);
        bus.run = 1'b1;
        step(6);
        bus.dbg_sel = 4'd5;
        #1;
        check("arith_acc", bus.acc, 16'h04);
        check("arith_r5", bus.dbg_data, 16'h02);
        check("arith_z", bus.zero_flag, 16'h0);
        check("arith_c", bus.carry_flag, 16'h0);
        check("arith_pc", bus.pc, 16'h3);
        check("arith_done", n_done, 16'd3);
        step(6);
        check("sub_acc", bus.acc, 16'h00);
        check("sub_z", bus.zero_flag, 16'h1);
        check("sub_c", bus.carry_flag, 16'h0);
        check("jz_taken_pc", bus.pc, 16'h9);
        step(4);
        check("jz_nt_z", bus.zero_flag, 16'h0);
        check("jz_nt_pc", bus.pc, 16'hB);

        // Asynchronous reset in the middle of an EXEC cycle
        step(1);
        check("pre_rst_exec", bus.instr_done, 16'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pc", bus.pc, 16'h0);
        check("mid_rst_acc", bus.acc, 16'h0);
        check("mid_rst_z", bus.zero_flag, 16'h0);
        check("mid_rst_c", bus.carry_flag, 16'h0);
        check("mid_rst_halt", bus.halted, 16'h0);
        check("mid_rst_done", bus.instr_done, 16'h0);
        for (int k = 0; k < 16; k++) begin
            bus.dbg_sel = k[3:0];
            #1;
            check($sformatf("mid_rst_r%0d", k), bus.dbg_data, 16'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Carry and borrow
        load_rom(8'hC0);
        rom[0] = 8'h10; rom[1] = 8'h70; rom[2] = 8'hA2; rom[3] = 8'h22;
        rom[4] = 8'h11; rom[5] = 8'h32;
        do_reset();
        bus.run = 1'b1;
        step(8);
        bus.dbg_sel = 4'd2;
        #1;
        check("add_acc", bus.acc, 16'hFE);
        check("add_c", bus.carry_flag, 16'h1);
        check("add_z", bus.zero_flag, 16'h0);
        check("store_r2", bus.dbg_data, 16'hFF);
        step(4);
        check("borrow_acc", bus.acc, 16'h02);
        check("borrow_c", bus.carry_flag, 16'h1);
        check("borrow_z", bus.zero_flag, 16'h0);
        check("borrow_pc", bus.pc, 16'h6);

        // Stall with run=0, then HALT at address 3
        load_rom(8'hC0);
        rom[0] = 8'h15; rom[3] = 8'hD0;
        do_reset();
        bus.run = 1'b1;
        step(2);
        check("ldi_acc", bus.acc, 16'h05);
        check("ldi_pc", bus.pc, 16'h1);
        bus.run = 1'b0;
        step(5);
        check("stall_done", n_done, 16'd1);
        check("stall_pc", bus.pc, 16'h1);
        check("stall_acc", bus.acc, 16'h05);
        check("stall_addr", bus.rom_addr, 16'h1);
        bus.run = 1'b1;
        step(4);
        check("pre_halt_pc", bus.pc, 16'h3);
        check("pre_halt_flag", bus.halted, 16'h0);
        step(2);
        check("halt_flag", bus.halted, 16'h1);
        check("halt_pc", bus.pc, 16'h3);
        for (int i = 0; i < 6; i++) begin
            bus.run = i[0];
            step(1);
        end
        check("halt_hold_pc", bus.pc, 16'h3);
        check("halt_hold_flag", bus.halted, 16'h1);
        check("halt_hold_acc", bus.acc, 16'h05);
        check("halt_hold_done", bus.instr_done, 16'h0);

        // PC wrap over 16 NOPs, then JMP to 0xF
        load_rom(8'hC0);
        do_reset();
        bus.run = 1'b1;
        step(30);
        check("wrap_pc15", bus.pc, 16'hF);
        step(2);
        check("wrap_pc0", bus.pc, 16'h0);
        check("wrap_done", n_done, 16'd16);
        rom[0] = 8'h8F;
        do_reset();
        bus.run = 1'b1;
        step(2);
        check("jmp_pc", bus.pc, 16'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard ceiling so the run can never hang
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000 ns");
        $fatal(1);
    end

endmodule

`default_nettype wire
